// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: packs a qualified bit stream into WIDTH-bit words on a valid/ready port.
// Define SIPO_PARITY_EN to append an even-parity bit to each frame and report parity_err.
module sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {DATA = 1'b0, PAR = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shift, sr_nxt, word;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done, drop;
`ifdef SIPO_PARITY_EN
  logic             word_par;
`endif

  always_comb sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], d} : {d, sr[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    done      = 1'b0;
    word      = sr_shift;
`ifdef SIPO_PARITY_EN
    word_par  = 1'b0;
`endif
    // an abort wins over a bit arriving on the same edge
    if (sync_clr) begin
      state_nxt = DATA;
      cnt_nxt   = '0;
    end else if (d_valid) begin
      case (state)
        DATA: begin
          sr_nxt = sr_shift;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
            cnt_nxt   = CW'(WIDTH);
            state_nxt = PAR;
`else
            cnt_nxt   = '0;
            done      = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        PAR: begin
          // parity bit is not stored; the word is the already-shifted sr
          word      = sr;
          word_par  = (^sr) ^ d;
          done      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
`endif
        default: state_nxt = DATA;
      endcase
    end
  end

  assign drop = done && out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DATA;
      cnt       <= '0;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      if (done && !drop) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                parity_err <= 1'b0;
    else if (done && !drop) parity_err <= word_par;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: MSB-first and LSB-first instances driven by one stream,
// table of words plus hand sequences for overflow, back-to-back, sync_clr and mid-frame reset.
module tb_sipo_rx;

`ifdef SIPO_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       d = 1'b0, d_valid = 1'b0, sync_clr = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] out_data, lsb_data;
  logic       out_valid, parity_err, overflow;
  logic       lsb_valid, lsb_perr, lsb_ovf;

  int total = 0;
  int bad   = 0;

  sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sync_clr(sync_clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .overflow(overflow), .ovf_clr(ovf_clr));

  sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sync_clr(sync_clr),
    .out_data(lsb_data), .out_valid(lsb_valid), .out_ready(out_ready),
    .parity_err(lsb_perr), .overflow(lsb_ovf), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;     // word, sent MSB first on the wire
    logic       p;     // parity bit appended in parity builds
    logic [7:0] rev;   // expected LSB-first capture
    logic       perr;  // expected parity_err in parity builds
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    d = b; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
  endtask

  // rdy_last/clr_last drive out_ready/ovf_clr only on the frame's final edge
  task automatic send_frame(input logic [7:0] w, input logic p, input logic rdy_last,
                            input logic clr_last, input logic chk_lat);
    logic [8:0] f;
    int n;
    n = PEN ? 9 : 8;
    f = PEN ? {w, p} : {1'b0, w};
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0) begin
        if (chk_lat) chk("latency_pre", {31'b0, out_valid}, 32'd0);
        out_ready = rdy_last;
        ovf_clr   = clr_last;
      end
      send_bit(f[i]);
    end
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
    tbl[1] = '{8'h80, 1'b1, 8'h01, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
    tbl[3] = '{8'h12, 1'b0, 8'h48, 1'b0};
    tbl[4] = '{8'hF0, 1'b0, 8'h0F, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 8'h80, 1'b1};
    tbl[6] = '{8'hC8, 1'b1, 8'h13, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {24'b0, out_data}, 32'd0);
    chk("rst_perr", {31'b0, parity_err}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // first word: latency and accept
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_valid", {31'b0, out_valid}, 32'd1);
    chk("a5_data", {24'b0, out_data}, 32'hA5);
    drain();
    chk("a5_accept", {31'b0, out_valid}, 32'd0);
    chk("a5_hold", {24'b0, out_data}, 32'hA5);

    for (int k = 0; k < 7; k++) begin
      send_frame(tbl[k].w, tbl[k].p, 1'b0, 1'b0, 1'b0);
      chk("tbl_valid", {31'b0, out_valid}, 32'd1);
      chk("tbl_msb", {24'b0, out_data}, {24'b0, tbl[k].w});
      chk("tbl_lsb", {24'b0, lsb_data}, {24'b0, tbl[k].rev});
      chk("tbl_perr", {31'b0, parity_err}, {31'b0, PEN & tbl[k].perr});
      drain();
      chk("tbl_drain", {31'b0, out_valid}, 32'd0);
    end

    // overflow: second word dropped, holding register untouched
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_data", {24'b0, out_data}, 32'h3C);
    chk("ovf_valid", {31'b0, out_valid}, 32'd1);
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", {31'b0, overflow}, 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", {31'b0, overflow}, 32'd1);
    chk("ovf_data2", {24'b0, out_data}, 32'h3C);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    drain();

    // back-to-back: accept of 0x12 coincides with completion of 0x34
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_first", {24'b0, out_data}, 32'h12);
    send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_data", {24'b0, out_data}, 32'h34);
    chk("b2b_lsb", {24'b0, lsb_data}, 32'h2C);
    chk("b2b_no_ovf", {31'b0, overflow}, 32'd0);
    drain();

    // sync_clr after 5 bits, with a bit offered on the same edge
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    sync_clr = 1'b1; d = 1'b1; d_valid = 1'b1;
    tick();
    sync_clr = 1'b0; d_valid = 1'b0;
    chk("sclr_no_word", {31'b0, out_valid}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sclr_data", {24'b0, out_data}, 32'h5A);
    chk("sclr_valid", {31'b0, out_valid}, 32'd1);

    // async reset mid-frame with a held word and overflow set
    send_frame(8'hC8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_ovf", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1; #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_data", {24'b0, out_data}, 32'd0);
    chk("arst_ovf", {31'b0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_data", {24'b0, out_data}, 32'h96);
    chk("post_rst_lsb", {24'b0, lsb_data}, 32'h69);
    chk("post_rst_perr", {31'b0, parity_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
